// File: rtl/counter_pkg.sv
// Shared types for the counter / count-stream decoder pair: FSM states,
// step classes and direction encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_HOLD,
    STEP_JUMP
  } step_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_classifier.sv
// Combinational classifier: the modular difference between consecutive
// samples says whether the source stepped up, down, held or jumped.
module step_classifier
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output step_e            cls
);

  logic [WIDTH-1:0] delta;

  // Modulo subtraction makes wrap-around steps look like ordinary +/-1.
  assign delta = cur - prev;

  always_comb begin
    cls = STEP_JUMP;
    if (delta == WIDTH'(1))   cls = STEP_UP;
    else if (delta == '1)     cls = STEP_DOWN;
    else if (delta == '0)     cls = STEP_HOLD;
  end

endmodule

// File: rtl/count_stream_decoder.sv
// Recovers the step direction of a sampled up/down count bus, locks onto a
// clean step stream and counts discontinuities seen while locked.
module count_stream_decoder
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir,
  output logic             step_valid,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] last_count
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       acq_q, acq_d;
  logic             dir_d, sv_d, err_d;
  logic [ERRW-1:0]  errc_d;
  logic [WIDTH-1:0] last_d;
  step_e            cls;
  logic             legal;

  step_classifier #(.WIDTH(WIDTH)) u_cls (
    .prev (last_count),
    .cur  (count_in),
    .cls  (cls)
  );

  assign legal  = (cls == STEP_UP) || (cls == STEP_DOWN);
  assign locked = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    dir_d   = dir;
    sv_d    = 1'b0;
    err_d   = 1'b0;
    errc_d  = err_count;
    last_d  = last_count;
    if (sample_valid) begin
      last_d = count_in;
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          acq_d   = '0;
        end
        ACQUIRE: begin
          if (legal) begin
            dir_d = (cls == STEP_UP) ? DIR_UP : DIR_DOWN;
            if (acq_q + 4'd1 == LOCK_V) begin
              state_d = LOCKED;
              acq_d   = '0;
            end else begin
              acq_d = acq_q + 4'd1;
            end
          end else begin
            acq_d = '0;
          end
        end
        LOCKED: begin
          if (legal) begin
            sv_d  = 1'b1;
            dir_d = (cls == STEP_UP) ? DIR_UP : DIR_DOWN;
          end else begin
            // Discontinuity: report it and fall back to re-acquisition.
            err_d   = 1'b1;
            state_d = ACQUIRE;
            acq_d   = '0;
            if (err_count != '1) errc_d = err_count + ERRW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acq_q      <= '0;
      dir        <= 1'b0;
      step_valid <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      last_count <= '0;
    end else begin
      state_q    <= state_d;
      acq_q      <= acq_d;
      dir        <= dir_d;
      step_valid <= sv_d;
      err        <= err_d;
      err_count  <= errc_d;
      last_count <= last_d;
    end
  end

endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed bench for count_stream_decoder: lock acquisition, wrap steps,
// direction changes, hold/jump errors, idle cycles, reset and saturation.
module tb_count_stream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] count_in = '0;
  logic       dir, step_valid, locked, err;
  logic [7:0] err_count, last_count;

  int n_chk = 0;
  int n_bad = 0;

  count_stream_decoder #(.WIDTH(8), .LOCK_CNT(4), .ERRW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .count_in     (count_in),
    .dir          (dir),
    .step_valid   (step_valid),
    .locked       (locked),
    .err          (err),
    .err_count    (err_count),
    .last_count   (last_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of input, then look at the registered response.
  task automatic smp(input logic v, input logic [7:0] val);
    @(negedge clk);
    sample_valid = v;
    count_in     = val;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic d, input logic sv,
                         input logic lk, input logic e, input logic [7:0] ec,
                         input logic [7:0] lc);
    chk({tag, ".dir"},  {31'd0, dir},        {31'd0, d});
    chk({tag, ".sv"},   {31'd0, step_valid}, {31'd0, sv});
    chk({tag, ".lock"}, {31'd0, locked},     {31'd0, lk});
    chk({tag, ".err"},  {31'd0, err},        {31'd0, e});
    chk({tag, ".ec"},   {24'd0, err_count},  {24'd0, ec});
    chk({tag, ".last"}, {24'd0, last_count}, {24'd0, lc});
  endtask

  initial begin
    logic [7:0] v;

    // Reset state
    sample_valid = 1'b1;
    count_in     = 8'h77;
    @(posedge clk);
    #1;
    chk_out("rst0", 0, 0, 0, 0, 8'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Acquire on 0x10..0x14, first step_valid on 0x15
    smp(1, 8'h10); chk_out("acq10", 0, 0, 0, 0, 0, 8'h10);
    smp(1, 8'h11); chk_out("acq11", 1, 0, 0, 0, 0, 8'h11);
    smp(1, 8'h12); chk_out("acq12", 1, 0, 0, 0, 0, 8'h12);
    smp(1, 8'h13); chk_out("acq13", 1, 0, 0, 0, 0, 8'h13);
    smp(1, 8'h14); chk_out("acq14", 1, 0, 1, 0, 0, 8'h14);
    smp(1, 8'h15); chk_out("lk15",  1, 1, 1, 0, 0, 8'h15);

    // Wrap-around upward while locked
    do_reset();
    smp(1, 8'hF8);
    for (int i = 0; i < 4; i++) smp(1, 8'(8'hF9 + i));
    chk_out("lkFC", 1, 0, 1, 0, 0, 8'hFC);
    smp(1, 8'hFD); chk_out("upFD", 1, 1, 1, 0, 0, 8'hFD);
    smp(1, 8'hFE); chk_out("upFE", 1, 1, 1, 0, 0, 8'hFE);
    smp(1, 8'hFF); chk_out("upFF", 1, 1, 1, 0, 0, 8'hFF);
    smp(1, 8'h00); chk_out("up00", 1, 1, 1, 0, 0, 8'h00);
    smp(1, 8'h01); chk_out("up01", 1, 1, 1, 0, 0, 8'h01);

    // Direction changes while locked at 0x05
    for (int i = 2; i <= 5; i++) smp(1, 8'(i));
    chk_out("at05", 1, 1, 1, 0, 0, 8'h05);
    smp(1, 8'h04); chk_out("dn04", 0, 1, 1, 0, 0, 8'h04);
    smp(1, 8'h03); chk_out("dn03", 0, 1, 1, 0, 0, 8'h03);
    smp(1, 8'h04); chk_out("up04", 1, 1, 1, 0, 0, 8'h04);

    // Hold then jump from lock at 0x20
    do_reset();
    for (int i = 0; i < 5; i++) smp(1, 8'(8'h1C + i));
    chk_out("lk20", 1, 0, 1, 0, 0, 8'h20);
    smp(1, 8'h20); chk_out("hold", 1, 0, 0, 1, 1, 8'h20);
    smp(1, 8'h35); chk_out("jump", 1, 0, 0, 0, 1, 8'h35);
    smp(1, 8'h36); chk_out("re36", 1, 0, 0, 0, 1, 8'h36);
    smp(1, 8'h37); smp(1, 8'h38);
    chk_out("re38", 1, 0, 0, 0, 1, 8'h38);
    smp(1, 8'h39); chk_out("re39", 1, 0, 1, 0, 1, 8'h39);
    smp(1, 8'h3A); chk_out("re3A", 1, 1, 1, 0, 1, 8'h3A);

    // Idle cycles while locked: sample value must be ignored
    for (int i = 0; i < 3; i++) begin
      smp(0, 8'hC3);
      chk_out("idle", 1, 0, 1, 0, 1, 8'h3A);
    end
    smp(1, 8'h3B); chk_out("post_idle", 1, 1, 1, 0, 1, 8'h3B);

    // Two more errors to reach err_count = 3, relock, then reset mid-lock
    smp(1, 8'h3B); chk_out("e2", 1, 0, 0, 1, 2, 8'h3B);
    for (int i = 1; i <= 4; i++) smp(1, 8'(8'h3B + i));
    smp(1, 8'h3F); chk_out("e3", 1, 0, 0, 1, 3, 8'h3F);
    for (int i = 1; i <= 4; i++) smp(1, 8'(8'h3F + i));
    chk_out("lk43", 1, 0, 1, 0, 3, 8'h43);
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b1; count_in = 8'h44;
    @(posedge clk);
    #1;
    chk_out("midrst", 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    // IDLE behaviour after reset: first sample only becomes the reference
    smp(1, 8'h50); chk_out("idle50", 0, 0, 0, 0, 0, 8'h50);

    // 300 lock/hold rounds: err_count must stop at 255
    v = 8'h50;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        v = v + 8'd1;
        smp(1, v);
      end
      smp(1, v);
      if (i == 253) chk("sat254", {24'd0, err_count}, 32'd254);
      if (i == 254) chk("sat255", {24'd0, err_count}, 32'd255);
    end
    chk("sat_err", {31'd0, err}, 32'd1);
    chk("sat_final", {24'd0, err_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
